// File: rtl/pmcc_run_controller_pkg.sv
// Shared types for the pmcc run controller.
//   pmcc_run_state_t : run sequencer state encoding
//   trig_window()    : states in which trigger requests reach pmcc
package pmcc_run_controller_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        STEP  = 3'd3,
        END   = 3'd4
    } pmcc_run_state_t;

    function automatic logic trig_window(input pmcc_run_state_t s);
        return (s == RUN) || (s == STEP);
    endfunction

endpackage

// File: rtl/pmcc_run_controller_if.sv
// Register-block side of the pmcc run controller.
//   cmd_*        : single-cycle command pulses from software
//   cfg_*        : configuration levels (changed only while idle)
//   busy/done/tmo_err/done_irq/cycle_cnt : status back to the register block
// master = PMC register block, slave = run controller.
interface pmcc_run_controller_if #(
    parameter int PC_W  = 8,
    parameter int TMO_W = 16,
    parameter int CNT_W = 32
);
    logic             cmd_start;
    logic             cmd_stop;
    logic             cmd_step;
    logic             cmd_swtrig;
    logic             cfg_step_en;
    logic [PC_W-1:0]  cfg_end_pc;
    logic [TMO_W-1:0] cfg_timeout;
    logic             busy;
    logic             done;
    logic             tmo_err;
    logic             done_irq;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output cmd_start, cmd_stop, cmd_step, cmd_swtrig,
        output cfg_step_en, cfg_end_pc, cfg_timeout,
        input  busy, done, tmo_err, done_irq, cycle_cnt
    );

    modport slave (
        input  cmd_start, cmd_stop, cmd_step, cmd_swtrig,
        input  cfg_step_en, cfg_end_pc, cfg_timeout,
        output busy, done, tmo_err, done_irq, cycle_cnt
    );
endinterface

// File: rtl/pmcc_trig_sync.sv
// External trigger conditioning: two-flop synchronizer followed by a
// rising-edge detector.
//   clk, rst_n : clock, asynchronous active-low reset
//   async_in   : asynchronous trigger level
//   pulse      : one-cycle pulse per synchronized rising edge
module pmcc_trig_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic pulse
);
    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= async_in;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign pulse = sync & ~sync_d;
endmodule

// File: rtl/pmcc_run_controller.sv
// Run sequencer in front of the pixel-matrix coprocessor.
//   clk, rst_n  : clock, asynchronous active-low reset
//   ctl         : register-block commands, configuration and status
//   ext_trig    : asynchronous external trigger level
//   pc_if       : pmcc fetch PC
//   waitt       : pmcc is executing a WAIT instruction
//   pmcc_rst_n  : pmcc reset, low for RST_CYCLES cycles on start
//   pmcc_en     : pmcc advance enable
//   trigger     : one-cycle trigger pulse to pmcc
module pmcc_run_controller
    import pmcc_run_controller_pkg::*;
#(
    parameter int PC_W       = 8,
    parameter int TMO_W      = 16,
    parameter int CNT_W      = 32,
    parameter int RST_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pmcc_run_controller_if.slave ctl,
    input  logic                 ext_trig,
    input  logic [PC_W-1:0]      pc_if,
    input  logic                 waitt,
    output logic                 pmcc_rst_n,
    output logic                 pmcc_en,
    output logic                 trigger
);
    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

    pmcc_run_state_t  st;
    logic [RC_W-1:0]  rst_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W:0]   tmo_nxt;
    logic             ext_pulse;
    logic             end_hit;
    logic             tmo_hit;
    logic             trig_req;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [TMO_W-1:0] sat_inc_tmo(input logic [TMO_W-1:0] v);
        return (&v) ? v : v + TMO_W'(1);
    endfunction

    pmcc_trig_sync u_trig_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (ext_trig),
        .pulse    (ext_pulse)
    );

    // End conditions are judged on the cycle pmcc actually executes; the wait
    // counter is compared one ahead so the run ends on the Nth wait cycle itself.
    always_comb begin
        end_hit  = pmcc_en && (pc_if == ctl.cfg_end_pc);
        tmo_nxt  = {1'b0, tmo_cnt} + (TMO_W+1)'(1);
        tmo_hit  = pmcc_en && waitt && !trigger && (ctl.cfg_timeout != '0)
                   && (tmo_nxt == {1'b0, ctl.cfg_timeout});
        trig_req = (ext_pulse || ctl.cmd_swtrig) && trig_window(st);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st            <= IDLE;
            rst_cnt       <= '0;
            tmo_cnt       <= '0;
            pmcc_rst_n    <= 1'b1;
            pmcc_en       <= 1'b0;
            trigger       <= 1'b0;
            ctl.busy      <= 1'b0;
            ctl.done      <= 1'b0;
            ctl.tmo_err   <= 1'b0;
            ctl.done_irq  <= 1'b0;
            ctl.cycle_cnt <= '0;
        end else begin
            ctl.done_irq <= 1'b0;
            trigger      <= trig_req;
            if (pmcc_en) ctl.cycle_cnt <= sat_inc_cnt(ctl.cycle_cnt);
            if (!waitt || trigger) tmo_cnt <= '0;
            else if (pmcc_en)      tmo_cnt <= sat_inc_tmo(tmo_cnt);

            // Stop leaves pmcc out of reset so its state can be inspected.
            if (ctl.cmd_stop && (st inside {CLEAR, RUN, STEP})) begin
                st         <= IDLE;
                ctl.busy   <= 1'b0;
                pmcc_en    <= 1'b0;
                pmcc_rst_n <= 1'b1;
            end else begin
                unique case (st)
                    IDLE: begin
                        if (ctl.cmd_start && !ctl.cmd_stop) begin
                            st            <= CLEAR;
                            ctl.busy      <= 1'b1;
                            ctl.done      <= 1'b0;
                            ctl.tmo_err   <= 1'b0;
                            ctl.cycle_cnt <= '0;
                            rst_cnt       <= '0;
                            tmo_cnt       <= '0;
                            pmcc_rst_n    <= 1'b0;
                        end
                    end
                    CLEAR: begin
                        if (rst_cnt == RC_LAST) begin
                            pmcc_rst_n <= 1'b1;
                            st         <= ctl.cfg_step_en ? STEP : RUN;
                            pmcc_en    <= !ctl.cfg_step_en;
                        end else begin
                            rst_cnt <= rst_cnt + RC_W'(1);
                        end
                    end
                    RUN, STEP: begin
                        if (end_hit) begin
                            st           <= END;
                            pmcc_en      <= 1'b0;
                            ctl.done     <= 1'b1;
                            ctl.done_irq <= 1'b1;
                        end else if (tmo_hit) begin
                            st           <= END;
                            pmcc_en      <= 1'b0;
                            ctl.tmo_err  <= 1'b1;
                            ctl.done_irq <= 1'b1;
                        end else if (ctl.cfg_step_en) begin
                            st      <= STEP;
                            pmcc_en <= (st == STEP) && ctl.cmd_step;
                        end else begin
                            st      <= RUN;
                            pmcc_en <= 1'b1;
                        end
                    end
                    END: begin
                        st       <= IDLE;
                        ctl.busy <= 1'b0;
                    end
                    default: begin
                        st       <= IDLE;
                        ctl.busy <= 1'b0;
                        pmcc_en  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pmcc_run_controller.sv
module tb_pmcc_run_controller;
    localparam int PC_W       = 8;
    localparam int TMO_W      = 16;
    localparam int CNT_W      = 6;
    localparam int RST_CYCLES = 2;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;
    localparam int INF        = 1000000;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ext_trig;
    logic            waitt;
    logic            park;
    logic [PC_W-1:0] pc_m;
    logic [PC_W-1:0] pc_if;
    logic            pmcc_rst_n;
    logic            pmcc_en;
    logic            trigger;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pmcc_run_controller_if #(.PC_W(PC_W), .TMO_W(TMO_W), .CNT_W(CNT_W)) ctl ();

    pmcc_run_controller #(
        .PC_W(PC_W), .TMO_W(TMO_W), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ctl        (ctl),
        .ext_trig   (ext_trig),
        .pc_if      (pc_if),
        .waitt      (waitt),
        .pmcc_rst_n (pmcc_rst_n),
        .pmcc_en    (pmcc_en),
        .trigger    (trigger)
    );

    // Minimal pmcc stand-in: fetch PC restarts at 0 and advances once per enabled cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)           pc_m <= '0;
        else if (!pmcc_rst_n) pc_m <= '0;
        else if (pmcc_en)     pc_m <= pc_m + 8'd1;
    end
    assign pc_if = park ? PC_W'(5) : pc_m;

    typedef struct {
        int park;     int w;        int end_pc;   int tmo;
        int stop_at;  int start_at;
        int exp_en;   int exp_cnt;  int exp_done; int exp_tmo; int exp_irq;
    } run_t;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Reference: the run ends at the first of end-PC (tie wins) and timeout,
    // unless a stop arrives on or before that enabled cycle.
    function automatic run_t model(input run_t r);
        run_t o;
        int end_c, tmo_c, k;
        o = r;
        if (r.park != 0) end_c = (r.end_pc == 5) ? 1 : INF;
        else             end_c = r.end_pc + 1;
        tmo_c = (r.w != 0 && r.tmo != 0) ? r.tmo : INF;
        k = (end_c <= tmo_c) ? end_c : tmo_c;
        if (r.stop_at != 0 && r.stop_at <= k) begin
            o.exp_en = r.stop_at; o.exp_done = 0; o.exp_tmo = 0; o.exp_irq = 0;
        end else begin
            o.exp_en   = k;
            o.exp_done = (end_c <= tmo_c) ? 1 : 0;
            o.exp_tmo  = (end_c <= tmo_c) ? 0 : 1;
            o.exp_irq  = 1;
        end
        o.exp_cnt = (o.exp_en > CNT_MAX) ? CNT_MAX : o.exp_en;
        return o;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_pmcc_rst_n"}, pmcc_rst_n, 1);
        chk({tag, "_pmcc_en"}, pmcc_en, 0);
        chk({tag, "_trigger"}, trigger, 0);
        chk({tag, "_busy"}, ctl.busy, 0);
        chk({tag, "_done"}, ctl.done, 0);
        chk({tag, "_tmo_err"}, ctl.tmo_err, 0);
        chk({tag, "_done_irq"}, ctl.done_irq, 0);
        chk({tag, "_cycle_cnt"}, ctl.cycle_cnt, 0);
    endtask

    task automatic start_run(input int pk, input int w, input int endpc, input int tmo, input int stp);
        @(negedge clk);
        park = (pk != 0);
        waitt = (w != 0);
        ctl.cfg_end_pc  = PC_W'(endpc);
        ctl.cfg_timeout = TMO_W'(tmo);
        ctl.cfg_step_en = (stp != 0);
        ctl.cmd_start = 1'b1;
        @(negedge clk);
        ctl.cmd_start = 1'b0;
    endtask

    task automatic stop_run();
        ctl.cmd_stop = 1'b1;
        @(negedge clk);
        ctl.cmd_stop = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_run(input run_t r, input string tag);
        int irq, rlow, en, cyc;
        bit fin;
        irq = 0; rlow = 0; en = 0; cyc = 0; fin = 1'b0;
        start_run(r.park, r.w, r.end_pc, r.tmo, 0);
        while (!fin && cyc < 400) begin
            ctl.cmd_start = 1'b0;
            ctl.cmd_stop  = 1'b0;
            if (!pmcc_rst_n)  rlow++;
            if (ctl.done_irq) irq++;
            if (!ctl.busy) fin = 1'b1;
            else begin
                if (pmcc_en) begin
                    en++;
                    if (en == r.stop_at)  ctl.cmd_stop  = 1'b1;
                    if (en == r.start_at) ctl.cmd_start = 1'b1;
                end
                @(negedge clk);
                cyc++;
            end
        end
        chk({tag, "_finished"}, fin, 1);
        if (!fin) stop_run();
        chk({tag, "_en_cycles"}, en, r.exp_en);
        chk({tag, "_cycle_cnt"}, ctl.cycle_cnt, r.exp_cnt);
        chk({tag, "_done"}, ctl.done, r.exp_done);
        chk({tag, "_tmo_err"}, ctl.tmo_err, r.exp_tmo);
        chk({tag, "_irq_pulses"}, irq, r.exp_irq);
        chk({tag, "_rst_low"}, rlow, RST_CYCLES);
        chk({tag, "_en_after"}, pmcc_en, 0);
        chk({tag, "_rst_after"}, pmcc_rst_n, 1);
        @(negedge clk);
    endtask

    task automatic seq_swtrig();
        int en, tcnt, tat, irq;
        en = 0; tcnt = 0; tat = 0; irq = 0;
        start_run(1, 1, 16, 100, 0);
        for (int cyc = 0; cyc < 300; cyc++) begin
            ctl.cmd_swtrig = 1'b0;
            if (pmcc_en) en++;
            if (trigger) begin tcnt++; tat = en; end
            if (ctl.done_irq) irq++;
            if (en >= 140) break;
            if (pmcc_en && en == 50) ctl.cmd_swtrig = 1'b1;
            @(negedge clk);
        end
        chk("swtrig_reached_140", en, 140);
        chk("swtrig_pulses", tcnt, 1);
        chk("swtrig_pulse_cycle", tat, 51);
        chk("swtrig_no_irq", irq, 0);
        chk("swtrig_still_busy", ctl.busy, 1);
        chk("swtrig_no_tmo", ctl.tmo_err, 0);
        stop_run();
        chk("swtrig_cnt_saturated", ctl.cycle_cnt, CNT_MAX);
        chk("swtrig_done_clear", ctl.done, 0);
    endtask

    task automatic seq_ext();
        int tcnt;
        start_run(1, 0, 16, 0, 0);
        repeat (4) @(negedge clk);
        #2 ext_trig = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk($sformatf("ext_run_c%0d", i), trigger, (i == 3));
        end
        ext_trig = 1'b0;
        stop_run();
        tcnt = 0;
        #2 ext_trig = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (trigger) tcnt++;
        end
        chk("ext_idle_no_pulse", tcnt, 0);
        ext_trig = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic seq_step();
        int encnt, en_after, dbl, busy_low;
        bit prev_en, prev_step;
        encnt = 0; en_after = 0; dbl = 0; busy_low = 0;
        prev_en = 1'b0; prev_step = 1'b0;
        start_run(0, 0, 64, 0, 1);
        for (int i = 0; i < 30; i++) begin
            ctl.cmd_step = 1'b0;
            if (pmcc_en) begin
                encnt++;
                if (prev_step) en_after++;
                if (prev_en) dbl++;
            end
            if (!ctl.busy) busy_low++;
            prev_en   = pmcc_en;
            prev_step = (i == 4 || i == 9 || i == 14);
            ctl.cmd_step = prev_step;
            @(negedge clk);
        end
        ctl.cmd_step = 1'b0;
        chk("step_en_cycles", encnt, 3);
        chk("step_en_follows_cmd", en_after, 3);
        chk("step_en_back_to_back", dbl, 0);
        chk("step_busy_low_cycles", busy_low, 0);
        chk("step_cycle_cnt", ctl.cycle_cnt, 3);
        ctl.cfg_step_en = 1'b0;
        @(negedge clk);
        chk("step_off_runs", pmcc_en, 1);
        stop_run();
    endtask

    task automatic seq_reset();
        start_run(0, 0, 64, 0, 0);
        repeat (6) @(negedge clk);
        chk("rst_pre_en", pmcc_en, 1);
        chk("rst_pre_busy", ctl.busy, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        run_t tbl[12];
        run_t r;
        rst_n = 1'b0; ext_trig = 1'b0; waitt = 1'b0; park = 1'b0;
        ctl.cmd_start = 1'b0; ctl.cmd_stop = 1'b0; ctl.cmd_step = 1'b0;
        ctl.cmd_swtrig = 1'b0; ctl.cfg_step_en = 1'b0;
        ctl.cfg_end_pc = '0; ctl.cfg_timeout = '0;

        //         park w  end tmo stop start  en  cnt done tmo irq
        tbl[0]  = '{0, 0, 16,   0, 0, 0,    17, 17,  1,  0,  1};
        tbl[1]  = '{1, 1, 16, 100, 0, 0,   100, 63,  0,  1,  1};
        tbl[2]  = '{0, 0,  0,   0, 0, 0,     1,  1,  1,  0,  1};
        tbl[3]  = '{1, 1, 16,   1, 0, 0,     1,  1,  0,  1,  1};
        tbl[4]  = '{0, 1,  9,  10, 0, 0,    10, 10,  1,  0,  1};
        tbl[5]  = '{0, 1,  9,   9, 0, 0,     9,  9,  0,  1,  1};
        tbl[6]  = '{0, 0, 70,   0, 0, 0,    71, 63,  1,  0,  1};
        tbl[7]  = '{0, 0, 40,   0, 7, 0,     7,  7,  0,  0,  0};
        tbl[8]  = '{0, 0, 12,   0, 0, 3,    13, 13,  1,  0,  1};
        tbl[9]  = '{0, 0, 40,   0, 5, 5,     5,  5,  0,  0,  0};
        tbl[10] = '{0, 1, 20,   0, 0, 0,    21, 21,  1,  0,  1};
        tbl[11] = '{0, 0,  8,   0, 9, 0,     9,  9,  0,  0,  0};

        #23 check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 12; i++) do_run(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 24; i++) begin
            r.park     = ($urandom_range(0, 3) == 0) ? 1 : 0;
            r.w        = int'($urandom_range(0, 1));
            r.end_pc   = int'($urandom_range(0, 80));
            r.tmo      = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 90));
            r.stop_at  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 90)) : 0;
            r.start_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : 0;
            if (r.park != 0 && r.end_pc != 5 && (r.w == 0 || r.tmo == 0)) begin
                r.w   = 1;
                r.tmo = int'($urandom_range(1, 90));
            end
            r = model(r);
            do_run(r, $sformatf("rnd%0d", i));
        end

        seq_swtrig();
        seq_ext();
        seq_step();
        do_run(tbl[0], "pre_reset");
        seq_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
